data_memory_arbiter: RTL



---
 rtl/data_memory_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter in front of the single-port Data_Memory (core load/store vs auxiliary loader/DMA).
// Combinational grant, one access per cycle; optional alternation via DMA_ARB_ROUND_ROBIN_EN.
module data_memory_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int AUX_MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_stall_o,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              core_rvalid_o,
  input  logic              aux_req_i,
  input  logic              aux_we_i,
  input  logic [ADDR_W-1:0] aux_addr_i,
  input  logic [DATA_W-1:0] aux_wdata_i,
  input  logic              aux_lock_i,
  output logic              aux_gnt_o,
  output logic [DATA_W-1:0] aux_rdata_o,
  output logic              aux_rvalid_o,
  output logic              Mem_Read_o,
  output logic              Mem_Write_o,
  output logic [ADDR_W-1:0] Address_o,
  output logic [DATA_W-1:0] Write_Data_o,
  input  logic [DATA_W-1:0] Read_Data_i
);

  typedef enum logic [1:0] {IDLE, CORE_OWN, AUX_OWN, AUX_LOCK} state_t;

  localparam logic [7:0] MAX_WAIT = 8'(AUX_MAX_WAIT);

  state_t      state;
  logic [7:0]  aux_wait;
  logic        core_rvalid_q;
  logic        aux_rvalid_q;
  logic        lock_hold;
  logic        aged;
  logic        aux_pick;
  logic        core_gnt;
  logic        aux_gnt;

`ifdef DMA_ARB_ROUND_ROBIN_EN
  logic        last_gnt;  // 1 = aux was granted last
`endif

  always_comb begin
    lock_hold = (state == AUX_LOCK) & aux_req_i & aux_lock_i;
    aged      = (aux_wait == MAX_WAIT);
`ifdef DMA_ARB_ROUND_ROBIN_EN
    aux_pick  = aux_req_i & (~core_req_i | aged | ~last_gnt);
`else
    aux_pick  = aux_req_i & (~core_req_i | aged);
`endif
    // reset gating keeps any write from reaching memory while reset is high
    aux_gnt   = ~reset & (lock_hold | aux_pick);
    core_gnt  = ~reset & ~lock_hold & ~aux_pick & core_req_i;
  end

  assign core_gnt_o   = core_gnt;
  assign aux_gnt_o    = aux_gnt;
  assign core_stall_o = core_req_i & ~core_gnt;

  assign Mem_Write_o  = (core_gnt & core_we_i) | (aux_gnt & aux_we_i);
  assign Mem_Read_o   = (core_gnt & ~core_we_i) | (aux_gnt & ~aux_we_i);
  assign Address_o    = core_gnt ? core_addr_i  : (aux_gnt ? aux_addr_i  : '0);
  assign Write_Data_o = core_gnt ? core_wdata_i : (aux_gnt ? aux_wdata_i : '0);

  // a read granted just before reset rises must not surface as rvalid
  assign core_rvalid_o = core_rvalid_q & ~reset;
  assign aux_rvalid_o  = aux_rvalid_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      aux_wait      <= 8'd0;
      core_rvalid_q <= 1'b0;
      aux_rvalid_q  <= 1'b0;
      core_rdata_o  <= '0;
      aux_rdata_o   <= '0;
`ifdef DMA_ARB_ROUND_ROBIN_EN
      last_gnt      <= 1'b1;
`endif
    end else begin
      if (aux_gnt)
        state <= aux_lock_i ? AUX_LOCK : AUX_OWN;
      else if (core_gnt)
        state <= CORE_OWN;
      else
        state <= IDLE;

      if (~aux_req_i | aux_gnt)
        aux_wait <= 8'd0;
      else if (aux_wait != MAX_WAIT)
        aux_wait <= aux_wait + 8'd1;

      core_rvalid_q <= core_gnt & ~core_we_i;
      aux_rvalid_q  <= aux_gnt & ~aux_we_i;
      if (core_gnt & ~core_we_i)
        core_rdata_o <= Read_Data_i;
      if (aux_gnt & ~aux_we_i)
        aux_rdata_o <= Read_Data_i;

`ifdef DMA_ARB_ROUND_ROBIN_EN
      if (aux_gnt)
        last_gnt <= 1'b1;
      else if (core_gnt)
        last_gnt <= 1'b0;
`endif
    end
  end

endmodule
